// File: rtl/alu.sv
// Registered ALU execute stage: nine unsigned arithmetic/logic ops with
// carry/borrow/zero/parity/invalid flags, all outputs one cycle after sampling.
module alu #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           opcode,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op
);
  localparam int N = BUS_WIDTH;

  typedef enum logic [3:0] {
    OP_ADD = 4'd1, OP_ADC = 4'd2, OP_SUB = 4'd3, OP_INC = 4'd4, OP_DEC = 4'd5,
    OP_AND = 4'd6, OP_NOT = 4'd7, OP_ROL = 4'd8, OP_ROR = 4'd9
  } op_e;

  logic [N-1:0] y_d, y_q;
  logic         carry_d, carry_q, borrow_d, borrow_q;
  logic         zero_d, zero_q, parity_d, parity_q, inv_d, inv_q;
  logic [N:0]   a_x, b_x, ci_x, one_x, ext;

  assign a_x   = {1'b0, a};
  assign b_x   = {1'b0, b};
  assign ci_x  = {{N{1'b0}}, carry_in};
  assign one_x = {{N{1'b0}}, 1'b1};

  // N+1-bit results: the top bit is the carry (add) or borrow (subtract).
  always_comb begin
    ext      = '0;
    y_d      = '0;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    inv_d    = 1'b0;
    case (opcode)
      OP_ADD: begin ext = a_x + b_x;        {carry_d, y_d} = ext; end
      OP_ADC: begin ext = a_x + b_x + ci_x; {carry_d, y_d} = ext; end
      OP_SUB: begin ext = a_x - b_x;        {borrow_d, y_d} = ext; end
      OP_INC: begin ext = a_x + one_x;      {carry_d, y_d} = ext; end
      OP_DEC: begin ext = a_x - one_x;      {borrow_d, y_d} = ext; end
      OP_AND: y_d = a & b;
      OP_NOT: y_d = ~a;
      OP_ROL: y_d = {a[N-2:0], a[N-1]};
      OP_ROR: y_d = {a[0], a[N-1:1]};
      default: inv_d = 1'b1;
    endcase
    zero_d   = (y_d == '0);
    parity_d = ^y_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      y_q      <= y_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      inv_q    <= inv_d;
    end
  end

  assign y          = y_q;
  assign carry_out  = carry_q;
  assign borrow     = borrow_q;
  assign zero       = zero_q;
  assign parity     = parity_q;
  assign invalid_op = inv_q;
endmodule

// File: tb/tb_alu.sv
// Random + directed bench for alu; an integer-arithmetic model predicts every
// registered output and is compared against the DUT on each falling edge.
module tb_alu;
  localparam int W = 8;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   opcode;
  logic [W-1:0] a, b;
  logic         carry_in;
  logic [W-1:0] y;
  logic         carry_out, borrow, zero, parity, invalid_op;

  int checks = 0;
  int failures = 0;

  int e_y = 0, e_c = 0, e_b = 0, e_z = 0, e_p = 0, e_i = 0;

  alu #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .a(a), .b(b), .carry_in(carry_in),
    .y(y), .carry_out(carry_out), .borrow(borrow), .zero(zero), .parity(parity),
    .invalid_op(invalid_op)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the opcode table.
  task automatic model(input int op, input int av, input int bv, input int ci,
                       output int ry, output int rc, output int rb, output int ri);
    int s;
    ry = 0; rc = 0; rb = 0; ri = 0;
    case (op)
      1: begin s = av + bv;      ry = s & M; rc = s > M; end
      2: begin s = av + bv + ci; ry = s & M; rc = s > M; end
      3: begin ry = (av - bv) & M; rb = av < bv; end
      4: begin s = av + 1; ry = s & M; rc = s > M; end
      5: begin ry = (av - 1) & M; rb = (av == 0); end
      6: ry = av & bv;
      7: ry = ~av & M;
      8: ry = ((av << 1) | (av >> (W - 1))) & M;
      9: ry = ((av >> 1) | (av << (W - 1))) & M;
      default: ri = 1;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_y = 0; e_c = 0; e_b = 0; e_z = 0; e_p = 0; e_i = 0;
    end else begin
      model(int'(opcode), int'(a), int'(b), int'(carry_in), e_y, e_c, e_b, e_i);
      e_z = (e_y == 0);
      e_p = $countones(e_y) & 1;
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_y", int'(y), e_y);
    cmp("model_carry", int'(carry_out), e_c);
    cmp("model_borrow", int'(borrow), e_b);
    cmp("model_zero", int'(zero), e_z);
    cmp("model_parity", int'(parity), e_p);
    cmp("model_invalid", int'(invalid_op), e_i);
  end

  task automatic drive(input int op, input int av, input int bv, input int ci);
    opcode = op[3:0]; a = av[W-1:0]; b = bv[W-1:0]; carry_in = ci[0];
  endtask

  // Hand-computed literal checks, -1 means "not checked".
  task automatic dir(input string nm, input int op, input int av, input int bv, input int ci,
                     input int ey, input int ec, input int eb, input int ez, input int ep,
                     input int ei);
    @(negedge clk);
    drive(op, av, bv, ci);
    @(negedge clk);
    #1;
    cmp({nm, "_y"}, int'(y), ey);
    if (ec >= 0) cmp({nm, "_c"}, int'(carry_out), ec);
    if (eb >= 0) cmp({nm, "_b"}, int'(borrow), eb);
    if (ez >= 0) cmp({nm, "_z"}, int'(zero), ez);
    if (ep >= 0) cmp({nm, "_p"}, int'(parity), ep);
    if (ei >= 0) cmp({nm, "_i"}, int'(invalid_op), ei);
  endtask

  task automatic check_zero_outputs(input string nm);
    cmp({nm, "_y"}, int'(y), 0);
    cmp({nm, "_flags"}, int'({carry_out, borrow, zero, parity, invalid_op}), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 9, 33, 0);
    repeat (3) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    dir("add",   1,   9,  33, 0,  42, 0, 0, 0, 1, 0);
    dir("adc",   2,   9,  33, 1,  43, 0, 0, 0, 0, 0);
    dir("addc",  1, 200, 100, 0,  44, 1, 0, 0, -1, 0);
    dir("sub",   3,  65,  64, 0,   1, 0, 0, 0, -1, 0);
    dir("subb",  3,  65,  66, 0, 255, 0, 1, 0, 0, 0);
    dir("inc",   4, 233,   0, 1, 234, 0, 0, 0, -1, 0);
    dir("incw",  4, 255,   0, 0,   0, 1, 0, 1, 0, 0);
    dir("dec0",  5,   0,   0, 0, 255, 0, 1, 0, -1, 0);
    dir("and",   6,   2,   3, 1,   2, 0, 0, 0, -1, 0);
    dir("not",   7, 255,   0, 0,   0, 0, 0, 1, 0, 0);
    dir("rol1",  8,   1,   0, 0,   2, -1, -1, -1, -1, -1);
    dir("rol80", 8, 128,   0, 0,   1, -1, -1, -1, -1, -1);
    dir("ror80", 9, 128,   0, 0,  64, -1, -1, -1, -1, -1);
    dir("ror1",  9,   1,   0, 0, 128, -1, -1, -1, -1, -1);
    dir("inv0",  0,  55,  66, 1,   0, 0, 0, 1, 0, 1);
    dir("inv15", 15, 255, 255, 1,  0, 0, 0, 1, 0, 1);

    // Back-to-back random ops; the falling-edge compare checks each one.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive(int'($urandom_range(0, 15)), int'($urandom_range(0, M)),
            int'($urandom_range(0, M)), int'($urandom_range(0, 1)));
      if (i == 200) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
